twiddle_rotator135: RTL and testbench

//  Streaming twiddle-multiply stage for the 135-point DFT in the PUSCH transform-precoding path.

---
 rtl/fft135_pkg.sv | 30 +++
 rtl/twiddle_rotator135_twiddle.sv | 85 ++++++++
 rtl/twiddle_rotator135.sv | 132 +++++++++++++
 tb/tb_twiddle_rotator135.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft135_pkg.sv
// Shared constants and fixed-point helpers for the 135-point DFT datapath.
package fft135_pkg;

    localparam int N135 = 135;
    localparam int TWF  = 10;
    localparam int DW   = 18;
    localparam int PW   = 2 * DW;
    localparam int SW   = PW + 1;
    localparam int RW   = SW - TWF;

    localparam logic signed [SW-1:0] HALF_LSB = SW'(1) << (TWF - 1);
    localparam logic signed [RW-1:0] SAT_HI   = RW'((1 << (DW - 1)) - 1);
    localparam logic signed [RW-1:0] SAT_LO   = RW'(-(1 << (DW - 1)));

    function automatic logic signed [RW-1:0] roundShift(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] r;
        r = v + HALF_LSB;
        return r[SW-1:TWF];
    endfunction

    function automatic logic signed [DW-1:0] saturate(input logic signed [RW-1:0] v);
        if (v > SAT_HI) begin
            return SAT_HI[DW-1:0];
        end else if (v < SAT_LO) begin
            return SAT_LO[DW-1:0];
        end
        return v[DW-1:0];
    endfunction

endpackage

// File: rtl/twiddle_rotator135_twiddle.sv
// Twiddle135 ROM: floor(1024*cos(2*pi*a/135)), floor(-1024*sin(2*pi*a/135)), optional output register.
module Twiddle135
    import fft135_pkg::*;
#(
    parameter int TW_FF = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           addr_i,
    output logic signed [DW-1:0] wr_o,
    output logic signed [DW-1:0] wi_o
);

    localparam logic signed [127:0] ONE  = 128'sd1 <<< 60;
    localparam logic signed [127:0] PI60 = 128'sh3243F6A8885A308D;
    localparam logic signed [127:0] EPS  = 128'sd1 <<< 20;

    // Q60 Taylor series; argument is always folded into [0, pi/2] so terms stay small.
    function automatic logic signed [127:0] taylor(input logic signed [127:0] x, input logic isSin);
        logic signed [127:0] x2, term, sum;
        x2   = (x * x) >>> 60;
        term = isSin ? x : ONE;
        sum  = term;
        for (int k = 1; k <= 16; k++) begin
            if (isSin) begin
                term = -((term * x2) >>> 60) / 128'(2 * k * (2 * k + 1));
            end else begin
                term = -((term * x2) >>> 60) / 128'((2 * k - 1) * (2 * k));
            end
            sum = sum + term;
        end
        return sum;
    endfunction

    function automatic logic signed [DW-1:0] twiddle(input int a, input logic imagPart);
        logic signed [127:0] theta, c, s, v;
        int   m;
        logic sinNeg, cosNeg;
        sinNeg = (a > N135 / 2);
        m      = sinNeg ? N135 - a : a;
        theta  = (128'(m) * 128'sd2 * PI60) / 128'(N135);
        cosNeg = (4 * m > N135);
        if (cosNeg) begin
            theta = PI60 - theta;
        end
        c = taylor(theta, 1'b0);
        s = taylor(theta, 1'b1);
        if (cosNeg) begin
            c = -c;
        end
        if (sinNeg) begin
            s = -s;
        end
        v = imagPart ? -s : c;
        v = ((v <<< TWF) + EPS) >>> 60;
        return v[DW-1:0];
    endfunction

    logic signed [DW-1:0] romRe [N135];
    logic signed [DW-1:0] romIm [N135];

    for (genvar a = 0; a < N135; a++) begin : gRom
        assign romRe[a] = twiddle(a, 1'b0);
        assign romIm[a] = twiddle(a, 1'b1);
    end

    if (TW_FF != 0) begin : gFf
        logic signed [DW-1:0] wr_q, wi_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_q <= '0;
                wi_q <= '0;
            end else begin
                wr_q <= romRe[addr_i];
                wi_q <= romIm[addr_i];
            end
        end
        assign wr_o = wr_q;
        assign wi_o = wi_q;
    end else begin : gComb
        assign wr_o = romRe[addr_i];
        assign wi_o = romIm[addr_i];
    end

endmodule

// File: rtl/twiddle_rotator135.sv
// Streaming twiddle multiply for the 135-point DFT: addresses (n*k) mod 135 and rotates each
// sample by the returned (optionally conjugated) twiddle with a fixed latency of 3 cycles.
module twiddle_rotator135
    import fft135_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] in_re,
    input  logic signed [DW-1:0] in_im,
    input  logic [7:0]           k_in,
    input  logic                 inverse,
    output logic                 out_valid,
    output logic signed [DW-1:0] out_re,
    output logic signed [DW-1:0] out_im,
    output logic                 out_last
);

    localparam logic [7:0] LAST_N = 8'(N135 - 1);
    localparam logic [8:0] MOD_N  = 9'(N135);

    logic [7:0] nCnt_q, nCnt_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] kLat_q, kLat_d;
    logic       invLat_q, invLat_d;
    logic       firstBeat, lastBeat;
    logic [7:0] kEff, romAddr;
    logic [8:0] accSum;

    assign firstBeat = (nCnt_q == 8'd0);
    assign lastBeat  = (nCnt_q == LAST_N);
    assign kEff      = ({1'b0, k_in} >= MOD_N) ? k_in - 8'(N135) : k_in;
    assign accSum    = {1'b0, acc_q} + {1'b0, kLat_q};
    assign romAddr   = firstBeat ? 8'd0 : acc_q;

    // acc holds (n*k) mod 135 for the next beat; k and inverse are captured only at n==0.
    always_comb begin
        nCnt_d   = nCnt_q;
        acc_d    = acc_q;
        kLat_d   = kLat_q;
        invLat_d = invLat_q;
        if (in_valid) begin
            nCnt_d = lastBeat ? 8'd0 : nCnt_q + 8'd1;
            if (firstBeat) begin
                kLat_d   = kEff;
                invLat_d = inverse;
                acc_d    = kEff;
            end else if (lastBeat) begin
                acc_d = 8'd0;
            end else if (accSum >= MOD_N) begin
                acc_d = 8'(accSum - MOD_N);
            end else begin
                acc_d = accSum[7:0];
            end
        end
    end

    logic signed [DW-1:0] twRe, twIm, wiEff;

    Twiddle135 #(.TW_FF(1)) uTwiddle (
        .clk    (clk),
        .rst_n  (rst_n),
        .addr_i (romAddr),
        .wr_o   (twRe),
        .wi_o   (twIm)
    );

    logic                 v1_q, last1_q, inv1_q;
    logic signed [DW-1:0] xr1_q, xi1_q;
    logic                 v2_q, last2_q;
    logic signed [PW-1:0] pRR_q, pII_q, pRI_q, pIR_q;
    logic signed [SW-1:0] reSum, imSum;

    assign wiEff = inv1_q ? -twIm : twIm;
    assign reSum = SW'(pRR_q) - SW'(pII_q);
    assign imSum = SW'(pRI_q) + SW'(pIR_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nCnt_q    <= '0;
            acc_q     <= '0;
            kLat_q    <= '0;
            invLat_q  <= 1'b0;
            v1_q      <= 1'b0;
            last1_q   <= 1'b0;
            inv1_q    <= 1'b0;
            xr1_q     <= '0;
            xi1_q     <= '0;
            v2_q      <= 1'b0;
            last2_q   <= 1'b0;
            pRR_q     <= '0;
            pII_q     <= '0;
            pRI_q     <= '0;
            pIR_q     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
        end else begin
            nCnt_q   <= nCnt_d;
            acc_q    <= acc_d;
            kLat_q   <= kLat_d;
            invLat_q <= invLat_d;

            v1_q    <= in_valid;
            last1_q <= in_valid & lastBeat;
            if (in_valid) begin
                xr1_q  <= in_re;
                xi1_q  <= in_im;
                inv1_q <= firstBeat ? inverse : invLat_q;
            end

            v2_q    <= v1_q;
            last2_q <= last1_q;
            if (v1_q) begin
                pRR_q <= PW'(xr1_q) * PW'(twRe);
                pII_q <= PW'(xi1_q) * PW'(wiEff);
                pRI_q <= PW'(xr1_q) * PW'(wiEff);
                pIR_q <= PW'(xi1_q) * PW'(twRe);
            end

            // Output data is held between beats; only valid/last drop.
            out_valid <= v2_q;
            out_last  <= last2_q;
            if (v2_q) begin
                out_re <= saturate(roundShift(reSum));
                out_im <= saturate(roundShift(imSum));
            end
        end
    end

endmodule

// File: tb/tb_twiddle_rotator135.sv
// Randomized self-checking bench for twiddle_rotator135 against a real-valued twiddle model.
module tb_twiddle_rotator135;

    localparam int  NPT = 135;
    localparam real PI  = 3.14159265358979323846;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic signed [17:0] in_re, in_im;
    logic [7:0]         k_in;
    logic               inverse;
    logic               out_valid, out_last;
    logic signed [17:0] out_re, out_im;

    typedef struct {
        int     due;
        longint re;
        longint im;
        bit     last;
    } exp_t;

    exp_t   sb[$];
    longint logRe[$];
    longint logIm[$];
    longint frameRe[NPT];
    longint frameIm[NPT];
    int     compared   = 0;
    int     mismatched = 0;
    int     cycle      = 0;
    int     mN         = 0;
    int     mK         = 0;
    bit     mInv       = 1'b0;
    longint holdRe     = 0;
    longint holdIm     = 0;
    int     base;

    twiddle_rotator135 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_re     (in_re),
        .in_im     (in_im),
        .k_in      (k_in),
        .inverse   (inverse),
        .out_valid (out_valid),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    function automatic longint twRef(input int a, input bit imagPart);
        real ang, v;
        ang = 2.0 * PI * real'(a) / real'(NPT);
        v   = imagPart ? -1024.0 * $sin(ang) : 1024.0 * $cos(ang);
        return longint'($floor(v + 1.0e-9));
    endfunction

    function automatic longint roundSat(input longint v);
        longint r;
        r = (v + 512) >>> 10;
        if (r > 131071) r = 131071;
        else if (r < -131072) r = -131072;
        return r;
    endfunction

    function automatic longint randSample();
        return longint'($urandom_range(262143)) - 131072;
    endfunction

    function automatic longint logAt(input int idx, input bit imagPart);
        if (idx >= logRe.size()) return -999999;
        return imagPart ? logIm[idx] : logRe[idx];
    endfunction

    task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                               input logic signed [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, want %0d (cycle %0d)", tag, observed, expected, cycle);
        end
    endtask

    task automatic sampleOutputs();
        exp_t e;
        bit   expV;
        bit   expL;
        expV = 1'b0;
        expL = 1'b0;
        if (sb.size() > 0 && sb[0].due == cycle) begin
            e      = sb.pop_front();
            expV   = 1'b1;
            expL   = e.last;
            holdRe = e.re;
            holdIm = e.im;
        end
        checkOutput("out_valid", out_valid, expV);
        checkOutput("out_last", out_last, expL);
        checkOutput("out_re", out_re, holdRe);
        checkOutput("out_im", out_im, holdIm);
        if (out_valid === 1'b1) begin
            logRe.push_back(out_re);
            logIm.push_back(out_im);
        end
    endtask

    // One cycle: check what is due now, then drive the next input and predict its result.
    task automatic applyStimulus(input bit v, input longint xr, input longint xi,
                                 input int k, input bit inv);
        exp_t   e;
        longint wr, wi;
        int     a;
        @(negedge clk);
        cycle++;
        sampleOutputs();
        in_valid = v;
        in_re    = 18'(xr);
        in_im    = 18'(xi);
        k_in     = 8'(k);
        inverse  = inv;
        if (v) begin
            if (mN == 0) begin
                mK   = k % NPT;
                mInv = inv;
            end
            a  = (mN * mK) % NPT;
            wr = twRef(a, 1'b0);
            wi = twRef(a, 1'b1);
            if (mInv) wi = -wi;
            e.due  = cycle + 3;
            e.re   = roundSat(xr * wr - xi * wi);
            e.im   = roundSat(xr * wi + xi * wr);
            e.last = (mN == NPT - 1);
            sb.push_back(e);
            mN = (mN + 1) % NPT;
        end
    endtask

    task automatic sendFrame(input int k, input bit inv, input int gapPct, input int stopAt);
        for (int n = 0; n < stopAt; n++) begin
            for (int g = 0; g < 4 && int'($urandom_range(99)) < gapPct; g++) begin
                applyStimulus(1'b0, randSample(), randSample(), int'($urandom_range(255)),
                              bit'($urandom_range(1)));
            end
            if (n == 0) begin
                applyStimulus(1'b1, frameRe[n], frameIm[n], k, inv);
            end else begin
                applyStimulus(1'b1, frameRe[n], frameIm[n], int'($urandom_range(255)),
                              bit'($urandom_range(1)));
            end
        end
    endtask

    task automatic drain();
        repeat (4) applyStimulus(1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic fillConst(input longint re, input longint im);
        for (int n = 0; n < NPT; n++) begin
            frameRe[n] = re;
            frameIm[n] = im;
        end
    endtask

    task automatic fillImpulse(input int pos, input longint re, input longint im);
        fillConst(0, 0);
        frameRe[pos] = re;
        frameIm[pos] = im;
    endtask

    task automatic fillRandom();
        for (int n = 0; n < NPT; n++) begin
            frameRe[n] = randSample();
            frameIm[n] = randSample();
        end
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("rst_mid_valid", out_valid, 0);
        checkOutput("rst_mid_last", out_last, 0);
        sb.delete();
        mN     = 0;
        holdRe = 0;
        holdIm = 0;
        repeat (2) applyStimulus(1'b0, 0, 0, 0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_re    = '0;
        in_im    = '0;
        k_in     = '0;
        inverse  = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_last", out_last, 0);
        checkOutput("rst_re", out_re, 0);
        checkOutput("rst_im", out_im, 0);
        repeat (3) applyStimulus(1'b0, 0, 0, 0, 1'b0);
        rst_n = 1'b1;
        repeat (2) applyStimulus(1'b0, 0, 0, 0, 1'b0);

        // Identity twiddle: k=0 leaves every sample untouched.
        base = logRe.size();
        fillConst(1000, -500);
        sendFrame(0, 1'b0, 0, NPT);
        drain();
        checkOutput("k0_first_re", logAt(base, 1'b0), 1000);
        checkOutput("k0_last_im", logAt(base + NPT - 1, 1'b1), -500);

        // Unit impulse at n=1, forward then conjugate, back to back.
        base = logRe.size();
        fillImpulse(1, 1024, 0);
        sendFrame(1, 1'b0, 0, NPT);
        sendFrame(1, 1'b1, 0, NPT);
        drain();
        checkOutput("imp_fwd_re", logAt(base + 1, 1'b0), 1022);
        checkOutput("imp_fwd_im", logAt(base + 1, 1'b1), -48);
        checkOutput("imp_inv_re", logAt(base + NPT + 1, 1'b0), 1022);
        checkOutput("imp_inv_im", logAt(base + NPT + 1, 1'b1), 48);

        // Full-scale input near 88 degrees drives the real part into saturation.
        base = logRe.size();
        fillImpulse(33, 131071, 131071);
        sendFrame(1, 1'b0, 0, NPT);
        drain();
        checkOutput("sat_re", logAt(base + 33, 1'b0), 131071);
        checkOutput("sat_im", logAt(base + 33, 1'b1), -126591);

        // k above 134 folds back by 135.
        fillRandom();
        sendFrame(200, 1'b0, 0, NPT);
        drain();

        // Gapped input with a fresh k and direction each frame.
        repeat (4) begin
            fillRandom();
            sendFrame(int'($urandom_range(255)), bit'($urandom_range(1)), 40, NPT);
        end
        drain();

        // Reset in the middle of a frame, then a new frame must start at address 0.
        fillRandom();
        sendFrame(int'($urandom_range(1, 134)), 1'b0, 20, 70);
        pulseReset();
        base = logRe.size();
        fillRandom();
        sendFrame(int'($urandom_range(1, 255)), 1'b1, 0, NPT);
        drain();
        checkOutput("post_rst_re", logAt(base, 1'b0), frameRe[0]);
        checkOutput("post_rst_im", logAt(base, 1'b1), frameIm[0]);

        checkOutput("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
